// File: rtl/atmos_light_est_if.sv
// Pixel-in / atmospheric-light-out bundle for atmos_light_est.
// master drives the dark-channel stream; slave is the estimator.
interface atmos_light_est_if #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int DATA_WIDTH = 8
);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [DATA_WIDTH-1:0] in_val;
    logic                  in_valid;
    logic                  frame_restart;
    logic [DATA_WIDTH-1:0] a_val;
    logic [XW-1:0]         a_x;
    logic [YW-1:0]         a_y;
    logic                  a_valid;

    modport master (
        output in_val, in_valid, frame_restart,
        input  a_val, a_x, a_y, a_valid
    );

    modport slave (
        input  in_val, in_valid, frame_restart,
        output a_val, a_x, a_y, a_valid
    );
endinterface

// File: rtl/atmos_light_est.sv
// Per-frame brightest dark-channel pixel tracker; result registered 1 cycle after the last pixel.
// No backpressure: every in_valid is consumed. Optional temporal smoothing with macro ATMOS_IIR_EN.
module atmos_light_est #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int DATA_WIDTH = 8,
    parameter int A_MIN      = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    atmos_light_est_if.slave        bus
);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [DATA_WIDTH-1:0] AMIN_C = DATA_WIDTH'(A_MIN);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0]         r_col;
    logic [YW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_max;
    logic [XW-1:0]         r_mx;
    logic [YW-1:0]         r_my;
    logic [DATA_WIDTH-1:0] r_a_val;
    logic [XW-1:0]         r_a_x;
    logic [YW-1:0]         r_a_y;
    logic                  r_a_valid;

    logic [XW-1:0]         w_col;
    logic [YW-1:0]         w_row;
    logic                  w_first;
    logic                  w_eol;
    logic                  w_last;
    logic                  w_take;
    logic [DATA_WIDTH-1:0] w_max;
    logic [XW-1:0]         w_mx;
    logic [YW-1:0]         w_my;
    logic [XW-1:0]         w_col_nxt;
    logic [YW-1:0]         w_row_nxt;
    logic [DATA_WIDTH-1:0] w_filt;
    logic [DATA_WIDTH-1:0] w_clamp;

    // A restart alongside a pixel makes that pixel (0,0) of the new frame.
    assign w_col   = bus.frame_restart ? '0 : r_col;
    assign w_row   = bus.frame_restart ? '0 : r_row;
    assign w_first = (w_col == '0) && (w_row == '0);
    assign w_eol   = (w_col == X_LAST);
    assign w_last  = w_eol && (w_row == Y_LAST);

    // Strict greater-than keeps the earliest pixel on ties; (0,0) always seeds.
    assign w_take  = w_first || (bus.in_val > r_max);
    assign w_max   = w_take ? bus.in_val : r_max;
    assign w_mx    = w_take ? w_col : r_mx;
    assign w_my    = w_take ? w_row : r_my;

    assign w_col_nxt = w_eol ? '0 : w_col + 1'b1;
    assign w_row_nxt = !w_eol ? w_row : (w_row == Y_LAST) ? '0 : w_row + 1'b1;

`ifdef ATMOS_IIR_EN
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_hist_vld;
    logic [DATA_WIDTH+1:0] w_sum;

    assign w_sum  = ({2'b00, r_prev} << 1) + {2'b00, r_prev} + {2'b00, w_max}
                  + (DATA_WIDTH+2)'(2);
    assign w_filt = r_hist_vld ? w_sum[DATA_WIDTH+1:2] : w_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '0;
            r_hist_vld <= 1'b0;
        end else if (bus.in_valid && w_last) begin
            r_prev     <= w_filt;
            r_hist_vld <= 1'b1;
        end
    end
`else
    assign w_filt = w_max;
`endif

    assign w_clamp = (w_filt < AMIN_C) ? AMIN_C : w_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_max     <= '0;
            r_mx      <= '0;
            r_my      <= '0;
            r_a_val   <= '0;
            r_a_x     <= '0;
            r_a_y     <= '0;
            r_a_valid <= 1'b0;
        end else begin
            r_a_valid <= 1'b0;
            if (bus.in_valid) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                r_max <= w_max;
                r_mx  <= w_mx;
                r_my  <= w_my;
                if (w_last) begin
                    r_a_val   <= w_clamp;
                    r_a_x     <= w_mx;
                    r_a_y     <= w_my;
                    r_a_valid <= 1'b1;
                end
            end else if (bus.frame_restart) begin
                r_col <= '0;
                r_row <= '0;
                r_max <= '0;
                r_mx  <= '0;
                r_my  <= '0;
            end
        end
    end

    assign bus.a_val   = r_a_val;
    assign bus.a_x     = r_a_x;
    assign bus.a_y     = r_a_y;
    assign bus.a_valid = r_a_valid;
endmodule

// File: doc/atmos_light_est.md
ATMOS_LIGHT_EST -- requirements
Module: atmos_light_est

Interface
REQ-001 Parameter WIDTH, default 160, pixels per line of the dark-channel stream.
REQ-002 Parameter HEIGHT, default 120, lines per frame.
REQ-003 Parameter DATA_WIDTH, default 8, bits per dark-channel sample.
REQ-004 Parameter A_MIN, default 100, lower clamp applied to the reported atmospheric light.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_val  input  DATA_WIDTH  min-filtered dark-channel sample, raster order.
REQ-008 in_valid  input  1  in_val qualifier; one pixel per asserted cycle, gaps allowed.
REQ-009 frame_restart  input  1  synchronous resync; next accepted pixel becomes (0,0).
REQ-010 a_val  output  DATA_WIDTH  atmospheric light estimate, held between updates.
REQ-011 a_x  output  clog2(WIDTH)  column of the winning pixel.
REQ-012 a_y  output  clog2(HEIGHT)  row of the winning pixel.
REQ-013 a_valid  output  1  one-cycle pulse marking a new a_val/a_x/a_y.

Function
REQ-014 Column counter SHALL advance on each in_valid and wrap WIDTH-1 -> 0; on wrap the row counter advances and wraps HEIGHT-1 -> 0.
REQ-015 Running max SHALL update on strict greater-than only; ties keep the earliest pixel in raster order.
REQ-016 The first pixel of each frame (0,0) SHALL load the tracker unconditionally, regardless of the previous frame's max.
REQ-017 The last pixel (WIDTH-1,HEIGHT-1) SHALL take part in the comparison; a_valid pulses exactly 1 cycle after that pixel's in_valid cycle.
REQ-018 On the a_valid cycle, a_val/a_x/a_y SHALL present the frame result and hold until the next a_valid.
REQ-019 a_val SHALL equal max(result, A_MIN); a_x/a_y are never clamped.
REQ-020 A first pixel of the next frame arriving on the cycle directly after the last pixel SHALL be accepted with no bubble and no corruption of the reported result.
REQ-021 frame_restart SHALL zero both counters and invalidate the tracker, with no a_valid generated for the partial frame.
REQ-022 frame_restart together with in_valid SHALL count that pixel as (0,0) of the new frame.
REQ-023 in_valid low SHALL freeze counters and tracker.
REQ-024 Comparisons SHALL be unsigned, DATA_WIDTH bits.

Reset
REQ-025 rst SHALL clear a_val, a_x, a_y, a_valid, both counters, the tracker and the IIR history to 0.
REQ-026 rst mid-frame SHALL discard the partial frame; the first pixel after rst deasserts is (0,0).
REQ-027 rst SHALL take priority over frame_restart and in_valid.

Configuration
REQ-028 Macro ATMOS_IIR_EN defined: pre-clamp result = (3*prev + new + 2) >> 2 with a DATA_WIDTH+2-bit intermediate, where prev is the last unclamped filtered value. The first frame after rst passes new through directly.
REQ-029 ATMOS_IIR_EN undefined: pre-clamp result = frame max directly; no history register present.
REQ-030 a_x, a_y and a_valid timing SHALL be identical with and without ATMOS_IIR_EN.

Verification
(WIDTH=4, HEIGHT=2, A_MIN=100 unless stated)
REQ-031 Frame of 8 pixels, all 50 -> a_valid 1 cycle after 8th pixel; a_val=100 (clamp), a_x=0, a_y=0.
REQ-032 Pixels 10,200,30,200,5,5,5,5 -> a_val=200, a_x=1, a_y=0 (tie keeps first occurrence).
REQ-033 Max 250 at the last pixel with random in_valid gaps, then next frame's first pixel on the following cycle -> a_val=250, a_x=3, a_y=1; next frame result unaffected.
REQ-034 frame_restart asserted after 5 pixels, then a full frame with max 180 at (2,1) -> single a_valid; a_val=180, a_x=2, a_y=1.
REQ-035 rst asserted after 3 pixels -> all outputs 0; the next full frame reports correctly.
REQ-036 ATMOS_IIR_EN defined, frame maxima 200 then 120, A_MIN=0 -> a_val=200, then a_val=180.
